// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 timing constants and receiver lock states
package vga_timing_pkg;
  localparam int H_VISIBLE    = 640;
  localparam int H_FRONT      = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BACK       = 48;
  localparam int V_VISIBLE    = 480;
  localparam int V_FRONT      = 10;
  localparam int V_SYNC       = 2;
  localparam int V_BACK       = 33;
  localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  typedef enum logic [2:0] {SEARCH, LINE, WAIT_V, FRAME, LOCKED} lock_state_t;
endpackage

// File: rtl/sync_fall_detect.sv
// sync_fall_detect: registers an active-low sync pin and flags its falling edge
module sync_fall_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_fall
);
  logic r_q;
  // cleared in reset so a pin already low at release is not taken as an edge
  always_ff @(posedge clk) begin
    if (!rst) r_q <= 1'b0;
    else r_q <= i_pin;
  end
  assign o_fall = r_q & ~i_pin;
endmodule

// File: rtl/vga_timing_rx.sv
// vga_timing_rx: locks onto hsync/vsync and rebuilds the generator's h_cnt/v_cnt/valid
module vga_timing_rx #(
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       valid,
  output logic       locked,
  output logic       frame_start,
  output logic       err_line,
  output logic       err_frame
);
  import vga_timing_pkg::*;
  localparam int HTOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VTOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HSS  = H_VISIBLE + H_FRONT;
  localparam int VSS  = V_VISIBLE + V_FRONT;
  logic        w_hf, w_vf, w_line_ok, w_frame_ok, w_timeout, w_el, w_ef;
  logic [9:0]  r_h, r_v, r_lm, r_fm, w_h_nx, w_v_nx, w_lm_nx, w_fm_nx;
  logic        r_valid, r_locked, r_fs, r_el, r_ef;
  lock_state_t r_st, w_st_nx;
  sync_fall_detect u_hs (.clk(clk), .rst(rst), .i_pin(hsync), .o_fall(w_hf));
  sync_fall_detect u_vs (.clk(clk), .rst(rst), .i_pin(vsync), .o_fall(w_vf));
  always_comb begin
    w_h_nx     = w_hf ? 10'(HSS) : (r_h == 10'(HTOT - 1)) ? 10'd0 : r_h + 10'd1;
    w_v_nx     = w_vf ? 10'(VSS)
               : (!w_hf && r_h == 10'(HTOT - 1)) ? ((r_v == 10'(VTOT - 1)) ? 10'd0 : r_v + 10'd1)
               : r_v;
    w_lm_nx    = w_hf ? 10'd1 : (&r_lm) ? r_lm : r_lm + 10'd1;
    w_fm_nx    = w_vf ? {9'd0, w_hf} : (w_hf && !(&r_fm)) ? r_fm + 10'd1 : r_fm;
    w_line_ok  = r_lm == 10'(HTOT);
    w_frame_ok = r_fm == 10'(VTOT);
    w_timeout  = !w_hf && (&w_lm_nx);
  end
  // a bad line outranks any frame result seen in the same cycle
  always_comb begin
    w_st_nx = r_st;
    w_el    = 1'b0;
    w_ef    = 1'b0;
    if (w_timeout) w_st_nx = SEARCH;
    else if (r_st == SEARCH) w_st_nx = w_hf ? LINE : SEARCH;
    else if (w_hf && !w_line_ok) begin
      w_st_nx = LINE;
      w_el    = 1'b1;
    end else if (r_st == LINE) w_st_nx = w_hf ? WAIT_V : LINE;
    else if (r_st == WAIT_V) w_st_nx = w_vf ? FRAME : WAIT_V;
    else if (w_vf) begin
      w_st_nx = w_frame_ok ? LOCKED : FRAME;
      w_ef    = !w_frame_ok;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_h      <= '0;
      r_v      <= '0;
      r_lm     <= '0;
      r_fm     <= '0;
      r_st     <= SEARCH;
      r_valid  <= 1'b0;
      r_locked <= 1'b0;
      r_fs     <= 1'b0;
      r_el     <= 1'b0;
      r_ef     <= 1'b0;
    end else begin
      r_h      <= w_h_nx;
      r_v      <= w_v_nx;
      r_lm     <= w_lm_nx;
      r_fm     <= w_fm_nx;
      r_st     <= w_st_nx;
      r_valid  <= w_st_nx == LOCKED && w_h_nx < 10'(H_VISIBLE) && w_v_nx < 10'(V_VISIBLE);
      r_locked <= w_st_nx == LOCKED;
      r_fs     <= w_st_nx == LOCKED && w_h_nx == 10'd0 && w_v_nx == 10'd0;
      r_el     <= w_el;
      r_ef     <= w_ef;
    end
  end
  assign h_cnt       = r_h;
  assign v_cnt       = r_v;
  assign valid       = r_valid;
  assign locked      = r_locked;
  assign frame_start = r_fs;
  assign err_line    = r_el;
  assign err_frame   = r_ef;
endmodule
